spu32_cpu_lsu: RTL and testbench

SPU32_CPU_LSU -- requirements
Module: spu32_cpu_lsu

---
 rtl/spu32_cpu_lsu.sv | 117 +++++++++++
 tb/tb_spu32_cpu_lsu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spu32_cpu_lsu.sv
// Load/store unit: turns one RV32 load or store into a single 32-bit bus access.
// Handles byte-lane steering, load sign/zero extension, and faults on misaligned or illegal requests.
module spu32_cpu_lsu (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_en,
  input  logic        I_store,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_adr,
  input  logic [31:0] I_data,
  output logic        O_bus_req,
  output logic        O_bus_we,
  output logic [31:0] O_bus_addr,
  output logic [3:0]  O_bus_sel,
  output logic [31:0] O_bus_data,
  input  logic [31:0] I_bus_data,
  input  logic        I_bus_ack,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_data,
  output logic        O_error
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  adr_lo;
    logic [29:0] word_adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nx;
  req_t        req_q, req_d;
  logic        err_q;
  logic [31:0] data_q;
  logic        fault;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Request decode; only used when the request is accepted in IDLE.
  always_comb begin
    fault = (I_funct3[1:0] == 2'b11) || (I_funct3[2] && (I_funct3[1] || I_store)) ||
            ((I_funct3[1:0] == 2'b01) && I_adr[0]) ||
            ((I_funct3[1:0] == 2'b10) && (I_adr[1:0] != 2'b00));
    req_d          = '0;
    req_d.store    = I_store;
    req_d.funct3   = I_funct3;
    req_d.adr_lo   = I_adr[1:0];
    req_d.word_adr = I_adr[31:2];
    case (I_funct3[1:0])
      2'b00: begin
        req_d.sel   = 4'b0001 << I_adr[1:0];
        req_d.wdata = {4{I_data[7:0]}};
      end
      2'b01: begin
        req_d.sel   = 4'b0011 << I_adr[1:0];
        req_d.wdata = {2{I_data[15:0]}};
      end
      default: begin
        req_d.sel   = 4'b1111;
        req_d.wdata = I_data;
      end
    endcase
  end

  always_comb begin
    lane = I_bus_data >> {req_q.adr_lo, 3'b000};
    case (req_q.funct3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (I_en) state_nx = fault ? S_DONE : S_BUS;
      S_BUS:   if (I_bus_ack) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state  <= S_IDLE;
      req_q  <= '0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && I_en) begin
        req_q <= req_d;
        err_q <= fault;
      end
      if (state == S_BUS && I_bus_ack && !req_q.store)
        data_q <= load_ext;
    end
  end

  // Lane enables and write strobe are gated so nothing leaks onto the bus outside BUS.
  assign O_bus_req  = (state == S_BUS);
  assign O_bus_we   = O_bus_req && req_q.store;
  assign O_bus_sel  = O_bus_req ? req_q.sel : 4'b0000;
  assign O_bus_addr = {req_q.word_adr, 2'b00};
  assign O_bus_data = req_q.wdata;
  assign O_busy     = O_bus_req;
  assign O_done     = (state == S_DONE);
  assign O_error    = O_done && err_q;
  assign O_data     = data_q;

endmodule

// File: tb/tb_spu32_cpu_lsu.sv
// Scoreboard bench for spu32_cpu_lsu: stimulus pushes expected accesses, a negedge monitor checks bus and completion.
module tb_spu32_cpu_lsu;

  logic        I_clk = 1'b0;
  logic        I_reset, I_en, I_store, I_bus_ack;
  logic [2:0]  I_funct3;
  logic [31:0] I_adr, I_data, I_bus_data;
  logic        O_bus_req, O_bus_we, O_busy, O_done, O_error;
  logic [31:0] O_bus_addr, O_bus_data, O_data;
  logic [3:0]  O_bus_sel;

  spu32_cpu_lsu dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_en(I_en), .I_store(I_store),
    .I_funct3(I_funct3), .I_adr(I_adr), .I_data(I_data),
    .O_bus_req(O_bus_req), .O_bus_we(O_bus_we), .O_bus_addr(O_bus_addr),
    .O_bus_sel(O_bus_sel), .O_bus_data(O_bus_data), .I_bus_data(I_bus_data),
    .I_bus_ack(I_bus_ack), .O_busy(O_busy), .O_done(O_done), .O_data(O_data),
    .O_error(O_error)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: checks bus presentation against the head entry and retires it on O_done.
  always @(negedge I_clk) begin
    if (!I_reset) begin
      if (O_bus_req) begin
        if (exp_q.size() == 0 || exp_q[0].err) chk("bus_unexpected", 32'(O_bus_req), 32'd0);
        else begin
          chk({exp_q[0].nm, "_sel"},  32'(O_bus_sel), 32'(exp_q[0].sel));
          chk({exp_q[0].nm, "_addr"}, O_bus_addr, exp_q[0].addr);
          chk({exp_q[0].nm, "_we"},   32'(O_bus_we), 32'(exp_q[0].we));
          chk({exp_q[0].nm, "_busy"}, 32'(O_busy), 32'd1);
          if (exp_q[0].we) chk({exp_q[0].nm, "_wdata"}, O_bus_data, exp_q[0].wdata);
        end
      end
      if (O_done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'(O_done), 32'd0);
        else begin
          chk({exp_q[0].nm, "_err"},      32'(O_error), 32'(exp_q[0].err));
          chk({exp_q[0].nm, "_data"},     O_data, exp_q[0].data);
          chk({exp_q[0].nm, "_busy_low"}, 32'(O_busy), 32'd0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One access from IDLE; ackw = BUS cycles without ack before the acking cycle.
  task automatic run(input string nm, input logic st, input logic [2:0] f3,
                     input logic [31:0] adr, input logic [31:0] wd, input int ackw,
                     input logic [31:0] bw, input logic ex_err, input logic [31:0] ex_data,
                     input logic [3:0] ex_sel, input logic [31:0] ex_wdata);
    exp_q.push_back('{ex_err, ex_data, ex_sel, {adr[31:2], 2'b00}, st, ex_wdata, nm});
    I_en = 1'b1; I_store = st; I_funct3 = f3; I_adr = adr; I_data = wd;
    @(posedge I_clk); #1;
    I_en = 1'b0;
    if (ex_err) begin
      chk({nm, "_fault_lat1"}, 32'(O_done), 32'd1);
      chk({nm, "_fault_noreq"}, 32'(O_bus_req), 32'd0);
    end else begin
      for (int k = 0; k < ackw; k++) begin @(posedge I_clk); #1; end
      I_bus_ack = 1'b1; I_bus_data = bw;
      @(posedge I_clk); #1;
      I_bus_ack = 1'b0; I_bus_data = 32'hxxxx_xxxx;
      chk({nm, "_lat"}, 32'(O_done), 32'd1);
    end
    @(posedge I_clk); #1;
  endtask

  initial begin
    I_reset = 1'b1; I_en = 1'b0; I_store = 1'b0; I_funct3 = 3'b000;
    I_adr = '0; I_data = '0; I_bus_ack = 1'b0; I_bus_data = '0;
    repeat (2) @(posedge I_clk);
    #1;
    chk("rst_req",  32'(O_bus_req), 32'd0);
    chk("rst_we",   32'(O_bus_we),  32'd0);
    chk("rst_busy", 32'(O_busy),    32'd0);
    chk("rst_done", 32'(O_done),    32'd0);
    chk("rst_err",  32'(O_error),   32'd0);
    chk("rst_data", O_data,         32'd0);
    chk("rst_sel",  32'(O_bus_sel), 32'd0);
    I_reset = 1'b0;
    @(posedge I_clk); #1;

    run("lb",   0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    run("lhu",  0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'hBEEF_0000, 0, 32'h0000_BEEF, 4'b1100, 32'h0);
    run("sh",   1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 1, 32'h0, 0, 32'h0000_BEEF, 4'b1100, 32'hABCD_ABCD);
    run("lw_mis", 0, 3'b010, 32'h0000_4001, 32'h0, 0, 32'h0, 1, 32'h0000_BEEF, 4'b0000, 32'h0);
    run("lh",   0, 3'b001, 32'h0000_2000, 32'h0, 0, 32'h1234_8001, 0, 32'hFFFF_8001, 4'b0011, 32'h0);
    run("lbu",  0, 3'b100, 32'h0000_1001, 32'h0, 3, 32'h1122_F344, 0, 32'h0000_00F3, 4'b0010, 32'h0);
    run("sb",   1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 0, 32'h0, 0, 32'h0000_00F3, 4'b0010, 32'hA5A5_A5A5);
    run("sw",   1, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 2, 32'h0, 0, 32'h0000_00F3, 4'b1111, 32'hDEAD_BEEF);
    run("lw",   0, 3'b010, 32'h0000_8000, 32'h0, 1, 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 4'b1111, 32'h0);
    run("f3_011", 0, 3'b011, 32'h0000_0000, 32'h0, 0, 32'h0, 1, 32'hCAFE_BABE, 4'b0000, 32'h0);
    run("st_1xx", 1, 3'b100, 32'h0000_0000, 32'h0, 0, 32'h0, 1, 32'hCAFE_BABE, 4'b0000, 32'h0);
    run("lh_mis", 0, 3'b001, 32'h0000_0001, 32'h0, 0, 32'h0, 1, 32'hCAFE_BABE, 4'b0000, 32'h0);

    // Stalled store aborted by reset; a late ack must not complete it.
    exp_q.push_back('{1'b0, 32'h0, 4'b1111, 32'h0000_5000, 1'b1, 32'h0BAD_F00D, "sw_abort"});
    I_en = 1'b1; I_store = 1'b1; I_funct3 = 3'b010; I_adr = 32'h0000_5000; I_data = 32'h0BAD_F00D;
    @(posedge I_clk); #1;
    I_en = 1'b0;
    repeat (5) begin @(posedge I_clk); #1; end
    chk("abort_stalled_req", 32'(O_bus_req), 32'd1);
    I_reset = 1'b1; I_en = 1'b1; I_bus_ack = 1'b1;
    @(posedge I_clk); #1;
    exp_q.delete();
    chk("abort_req_low", 32'(O_bus_req), 32'd0);
    chk("abort_no_done", 32'(O_done),    32'd0);
    chk("abort_data_rst", O_data,        32'd0);
    I_reset = 1'b0; I_en = 1'b0;
    @(posedge I_clk); #1;
    I_bus_ack = 1'b0;
    chk("late_ack_no_done", 32'(O_done), 32'd0);
    repeat (2) begin @(posedge I_clk); #1; end
    run("lw_after_rst", 0, 3'b010, 32'h0000_9000, 32'h0, 0, 32'h0102_0304, 0, 32'h0102_0304, 4'b1111, 32'h0);

    // I_en held high: one bus cycle per acceptance, accesses separated by DONE.
    exp_q.push_back('{1'b0, 32'h55AA_55AA, 4'b1111, 32'h0000_6000, 1'b0, 32'h0, "hold_a"});
    I_en = 1'b1; I_store = 1'b0; I_funct3 = 3'b010; I_adr = 32'h0000_6000;
    @(posedge I_clk); #1;
    I_bus_ack = 1'b1; I_bus_data = 32'h55AA_55AA;
    @(posedge I_clk); #1;
    I_bus_ack = 1'b0;
    chk("hold_a_done", 32'(O_done), 32'd1);
    chk("hold_a_sep_req", 32'(O_bus_req), 32'd0);
    exp_q.push_back('{1'b0, 32'h1357_9BDF, 4'b1111, 32'h0000_6000, 1'b0, 32'h0, "hold_b"});
    @(posedge I_clk); #1;
    chk("hold_idle_req", 32'(O_bus_req), 32'd0);
    @(posedge I_clk); #1;
    chk("hold_b_req", 32'(O_bus_req), 32'd1);
    I_en = 1'b0; I_bus_ack = 1'b1; I_bus_data = 32'h1357_9BDF;
    @(posedge I_clk); #1;
    I_bus_ack = 1'b0;
    chk("hold_b_done", 32'(O_done), 32'd1);
    repeat (3) begin @(posedge I_clk); #1; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
